// File: rtl/eth_frame_parser.sv
// Ethernet frame parser behind the RMII receive stage: dibits -> bytes, DST filter,
// SRC/EtherType capture, payload stream with the trailing 4-byte FCS withheld.

module eth_frame_parser_dly #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full
);
  logic [DEPTH-1:0][7:0] dly;
  logic [DEPTH-1:0]      vld_pipe;

  // Occupancy rides alongside the data as a shift register; the oldest slot is
  // meaningful only once a 1 has shifted all the way through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly      <= '0;
      vld_pipe <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
    end else if (push) begin
      dly      <= {dly[DEPTH-2:0], din};
      vld_pipe <= {vld_pipe[DEPTH-2:0], 1'b1};
    end
  end

  assign dout = dly[DEPTH-1];
  assign full = vld_pipe[DEPTH-1];
endmodule

module eth_frame_parser #(
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter bit          PROMISC  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  axiid,
  input  logic        axiiv,
  output logic [7:0]  axiod,
  output logic        axiov,
  output logic [47:0] src_mac,
  output logic [15:0] ethertype,
  output logic        hdr_valid,
  output logic        frame_done,
  output logic        frame_err,
  output logic [10:0] payload_len
);
  typedef enum logic [2:0] {SYNC, IDLE, DST, SRC, TYPE, PAYLOAD, DROP} state_t;

  localparam logic [10:0] BCNT_MAX = 11'h7FF;
  localparam logic [10:0] MIN_LEN  = 11'd18;

  state_t      state;
  logic [1:0]  dcnt;
  logic [5:0]  sr;
  logic [10:0] bcnt;
  logic        ovf;
  logic        uc_ok;
  logic        bc_ok;

  logic [7:0]  rx_byte;
  logic        byte_done;
  logic [7:0]  mac_byte;
  logic        uc_hit;
  logic        bc_hit;
  logic        dly_clr;
  logic        dly_push;
  logic [7:0]  dly_out;
  logic        dly_full;

  assign rx_byte   = {axiid, sr};
  assign byte_done = axiiv && (dcnt == 2'd3);

  always_comb begin
    mac_byte = MAC_ADDR[7:0];
    case (bcnt[2:0])
      3'd0:    mac_byte = MAC_ADDR[47:40];
      3'd1:    mac_byte = MAC_ADDR[39:32];
      3'd2:    mac_byte = MAC_ADDR[31:24];
      3'd3:    mac_byte = MAC_ADDR[23:16];
      3'd4:    mac_byte = MAC_ADDR[15:8];
      default: mac_byte = MAC_ADDR[7:0];
    endcase
  end

  // Unicast and broadcast matches are tracked independently so a mix of the two
  // across bytes 0-5 is still a reject.
  assign uc_hit = uc_ok && (rx_byte == mac_byte);
  assign bc_hit = bc_ok && (rx_byte == 8'hFF);

  assign dly_clr  = (state == IDLE) && axiiv;
  assign dly_push = (state == PAYLOAD) && byte_done;

  eth_frame_parser_dly #(.DEPTH(4)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .clr  (dly_clr),
    .push (dly_push),
    .din  (rx_byte),
    .dout (dly_out),
    .full (dly_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SYNC;
      dcnt        <= '0;
      sr          <= '0;
      bcnt        <= '0;
      ovf         <= 1'b0;
      uc_ok       <= 1'b0;
      bc_ok       <= 1'b0;
      axiod       <= '0;
      axiov       <= 1'b0;
      src_mac     <= '0;
      ethertype   <= '0;
      hdr_valid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      payload_len <= '0;
    end else begin
      axiov      <= 1'b0;
      hdr_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        SYNC: if (!axiiv) state <= IDLE;
        IDLE: begin
          if (axiiv) begin
            state       <= DST;
            dcnt        <= 2'd1;
            sr          <= {4'b0, axiid};
            bcnt        <= '0;
            ovf         <= 1'b0;
            uc_ok       <= 1'b1;
            bc_ok       <= 1'b1;
            payload_len <= '0;
          end
        end
        DROP: if (!axiiv) state <= IDLE;
        default: begin
          if (!axiiv) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            frame_err  <= (dcnt != 2'd0) || (bcnt < MIN_LEN) || ovf;
          end else begin
            dcnt <= dcnt + 2'd1;
            case (dcnt)
              2'd0:    sr[1:0] <= axiid;
              2'd1:    sr[3:2] <= axiid;
              2'd2:    sr[5:4] <= axiid;
              default: ;
            endcase
            if (byte_done) begin
              if (bcnt == BCNT_MAX) ovf <= 1'b1;
              else                  bcnt <= bcnt + 11'd1;
              case (state)
                DST: begin
                  uc_ok <= uc_hit;
                  bc_ok <= bc_hit;
                  if (bcnt == 11'd5)
                    state <= (PROMISC || uc_hit || bc_hit) ? SRC : DROP;
                end
                SRC: begin
                  src_mac <= {src_mac[39:0], rx_byte};
                  if (bcnt == 11'd11) state <= TYPE;
                end
                TYPE: begin
                  ethertype <= {ethertype[7:0], rx_byte};
                  if (bcnt == 11'd13) begin
                    hdr_valid <= 1'b1;
                    state     <= PAYLOAD;
                  end
                end
                PAYLOAD: begin
                  // A push into a full line releases its oldest byte: whatever is
                  // still held when the frame ends is the FCS.
                  if (dly_full) begin
                    axiod <= dly_out;
                    axiov <= 1'b1;
                    if (payload_len != BCNT_MAX) payload_len <= payload_len + 11'd1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end
endmodule

// File: doc/eth_frame_parser.md
# eth_frame_parser

Downstream consumer of the RMII receive stage. Takes the preamble/SFD-stripped dibit stream (2 bits per clock, LSB dibit of each byte first) and does four things:
- assembles the dibits into bytes;
- filters frames on destination MAC;
- captures source MAC and EtherType;
- emits payload bytes with the trailing 4-byte FCS withheld and discarded.

Output feeds the packet/game-state decoder as a byte stream with per-frame completion status.

## Interface
Parameters:
- MAC_ADDR, 48'h02_00_00_00_00_01, local station address; first received byte maps to bits [47:40].
- PROMISC, 0, 1 = accept every destination address.

Ports:
- clk  input  1  system clock (50 MHz RMII domain).
- rst  input  1  reset, asynchronous, active-high.
- axiid  input  2  dibit from receive stage.
- axiiv  input  1  dibit valid; a frame is one contiguous run of axiiv=1.
- axiod  output  8  payload byte.
- axiov  output  1  one-cycle strobe per payload byte.
- src_mac  output  48  source MAC of current/last accepted frame.
- ethertype  output  16  EtherType of current/last accepted frame; byte 12 goes to [15:8].
- hdr_valid  output  1  one-cycle pulse when header bytes 0-13 of an accepted frame are complete.
- frame_done  output  1  one-cycle pulse at end of an accepted frame.
- frame_err  output  1  status qualified by frame_done; held until the next frame_done.
- payload_len  output  11  bytes emitted on axiod for the frame; valid with frame_done.

## Operation
- Reset values: all outputs 0; state SYNC.
- Byte assembly:
  - A 2-bit dibit counter is incremented on each axiiv=1 cycle.
  - Dibit n of a byte goes to bits [2n+1:2n].
  - A byte completes on the 4th dibit.
  - A byte counter (11 bits) saturates at 2047.
- States:
  - SYNC: wait for axiiv=0, then go to IDLE. Prevents parsing a frame entered mid-stream after reset.
  - IDLE: axiiv=1 starts a frame and captures the dibit that cycle; go to DST.
  - DST (bytes 0-5): compare each byte against MAC_ADDR, or against FF:FF:FF:FF:FF:FF for broadcast. Any mismatch while PROMISC=0 goes to DROP once byte 5 completes.
  - SRC (bytes 6-11): shift into src_mac, MSB first.
  - TYPE (bytes 12-13): capture ethertype. On completion of byte 13, pulse hdr_valid and go to PAYLOAD.
  - PAYLOAD: push each completed byte into a 4-entry FIFO delay line. When a push finds the delay line already holding 4 bytes, emit the oldest byte on axiod with axiov=1 and increment payload_len.
  - DROP: no outputs of any kind; go to IDLE on axiiv=0. No frame_done for dropped frames.
- End of frame (axiiv=0 while in DST/SRC/TYPE/PAYLOAD):
  - Pulse frame_done and go to IDLE.
  - The 4 bytes left in the delay line are the FCS and are discarded; the CRC value is not checked.
  - frame_err=1 if the dibit count is not 0 mod 4 (partial byte) or total bytes < 18.
  - A truncated header still produces frame_done with frame_err=1, unless the DST check has already rejected the frame.
- Per-frame clearing: at frame start, clear the delay line, counters and payload_len. src_mac and ethertype are overwritten only as their bytes arrive.
- Width rule: total bytes beyond 2047 saturate. payload_len saturates at 2047. This sets frame_err.

## Timing
- All outputs are registered.
- Byte k completes on the edge that samples its 4th dibit, at cycle 4k+3 relative to the first dibit at cycle 0.
- axiov for payload byte j (frame byte 14+j) is high for the single cycle following the edge that completes frame byte 18+j. Latency is therefore 4 bytes (16 cycles) plus 1 clock.
- hdr_valid is high in the cycle after the edge that samples the last dibit of byte 13.
- frame_done is high in the cycle after the edge that samples the first axiiv=0.
  - axiov is never high in that same cycle.
  - frame_err and payload_len are stable when frame_done=1.
- Back-to-back frames separated by one axiiv=0 cycle are both parsed. IDLE accepts axiiv=1 on the cycle right after the frame_done edge.
- axiiv is never asserted non-contiguously within a frame; any single low cycle terminates the frame.
- Reset mid-frame: outputs go to 0 asynchronously. After release, the block stays in SYNC until axiiv=0, so the remainder of that frame is ignored.

## Test plan
- Unicast frame to MAC_ADDR, src 0A:0B:0C:0D:0E:0F, type 0x0800, 46 payload bytes 0x00..0x2D, 4-byte FCS:
  - hdr_valid once, src_mac=48'h0A0B0C0D0E0F, ethertype=16'h0800;
  - 46 axiov strobes in order 0x00..0x2D, first one 16 cycles + 1 clock after byte 14 completes;
  - frame_done with payload_len=46, frame_err=0.
- Broadcast destination with PROMISC=0 is accepted. Destination 02:00:00:00:00:02 is dropped: zero axiov, hdr_valid or frame_done pulses.
- Frame of 72 dibits plus 2 extra dibits (partial byte): frame_done with frame_err=1, payload_len=0.
- 16-byte frame: no axiov; frame_done with frame_err=1.
- Two 64-byte frames separated by one idle cycle: two frame_done pulses, each with payload_len=46, frame_err=0.
- Assert rst at byte 30 of a frame, release with axiiv still high:
  - outputs 0 immediately;
  - no activity for the rest of that frame;
  - the next frame parses normally.
